// File: rtl/render_scheduler_if.sv
// rtl/render_scheduler_if.sv - scheduler control/clear/status signal bundle
// master: render_scheduler side; slave: host/display/generator side.
interface render_scheduler_if #(
    parameter int ADDR_BITS         = 17,
    parameter int ZBUFFER_DATA_BITS = 20
);
    logic                         enable;
    logic                         vsync;
    logic [15:0]                  clear_color;
    logic                         gen_frame_start;
    logic                         gen_frame_done;
    logic                         clr_wr_en;
    logic [ADDR_BITS-1:0]         clr_wr_addr;
    logic [15:0]                  clr_fb_data;
    logic [ZBUFFER_DATA_BITS-1:0] clr_z_data;
    logic                         front_sel;
    logic                         back_sel;
    logic                         vram_lock;
    logic                         busy;
    logic [15:0]                  frame_count;
    logic                         timeout_err;

    modport master (
        input  enable, vsync, clear_color, gen_frame_done,
        output gen_frame_start, clr_wr_en, clr_wr_addr, clr_fb_data, clr_z_data,
               front_sel, back_sel, vram_lock, busy, frame_count, timeout_err
    );

    modport slave (
        output enable, vsync, clear_color, gen_frame_done,
        input  gen_frame_start, clr_wr_en, clr_wr_addr, clr_fb_data, clr_z_data,
               front_sel, back_sel, vram_lock, busy, frame_count, timeout_err
    );
endinterface

// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - per-frame clear/render/swap sequencer
// Define RENDER_SCHED_DOUBLE_BUFFER_EN to toggle front/back buffer selects on swap.
module render_scheduler #(
    parameter int                           DISPLAY_WIDTH     = 320,
    parameter int                           DISPLAY_HEIGHT    = 240,
    parameter int                           ZBUFFER_DATA_BITS = 20,
    parameter logic [ZBUFFER_DATA_BITS-1:0] Z_CLEAR           = 20'hFFFFF,
    parameter int                           TIMEOUT_CYCLES    = 1048576,
    parameter int                           ADDR_BITS         = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT)
) (
    input  logic                 clk,
    input  logic                 rst,
    render_scheduler_if.master   bus
);

    localparam int PIXELS  = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int WD_BITS = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(PIXELS - 1);
    localparam logic [WD_BITS-1:0]   WD_LAST   = WD_BITS'(TIMEOUT_CYCLES - 1);

`ifdef RENDER_SCHED_DOUBLE_BUFFER_EN
    localparam logic DB_EN = 1'b1;
`else
    localparam logic DB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_START,
        S_RENDER,
        S_WAIT_VSYNC,
        S_SWAP
    } state_t;

    state_t               r_state;
    logic [ADDR_BITS-1:0] r_addr;
    logic [15:0]          r_fb_data;
    logic                 r_clr_wr_en;
    logic                 r_gen_start;
    logic                 r_front;
    logic                 r_back;
    logic                 r_lock;
    logic                 r_busy;
    logic [15:0]          r_frame_count;
    logic                 r_err;
    logic [WD_BITS-1:0]   r_wd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_fb_data     <= '0;
            r_clr_wr_en   <= 1'b0;
            r_gen_start   <= 1'b0;
            r_front       <= 1'b0;
            r_back        <= DB_EN;
            r_lock        <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_count <= '0;
            r_err         <= 1'b0;
            r_wd          <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_fb_data   <= bus.clear_color;
                        r_addr      <= '0;
                        r_clr_wr_en <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (r_addr == LAST_ADDR) begin
                        r_clr_wr_en <= 1'b0;
                        r_addr      <= '0;
                        r_gen_start <= 1'b1;
                        r_lock      <= 1'b1;
                        r_state     <= S_START;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                S_START: begin
                    r_gen_start <= 1'b0;
                    r_wd        <= '0;
                    r_state     <= S_RENDER;
                end
                S_RENDER: begin
                    // Completion takes priority over a same-cycle timeout.
                    if (bus.gen_frame_done) begin
                        r_lock  <= 1'b0;
                        r_state <= S_WAIT_VSYNC;
                    end else if (r_wd == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_lock  <= 1'b0;
                        r_state <= S_WAIT_VSYNC;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                S_WAIT_VSYNC: begin
                    if (bus.vsync) begin
                        r_state <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    r_frame_count <= r_frame_count + 1'b1;
                    if (DB_EN) begin
                        r_front <= ~r_front;
                        r_back  <= r_front;
                    end
                    if (bus.enable) begin
                        r_fb_data   <= bus.clear_color;
                        r_addr      <= '0;
                        r_clr_wr_en <= 1'b1;
                        r_state     <= S_CLEAR;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gen_frame_start = r_gen_start;
    assign bus.clr_wr_en       = r_clr_wr_en;
    assign bus.clr_wr_addr     = r_addr;
    assign bus.clr_fb_data     = r_fb_data;
    assign bus.clr_z_data      = Z_CLEAR;
    assign bus.front_sel       = r_front;
    assign bus.back_sel        = r_back;
    assign bus.vram_lock       = r_lock;
    assign bus.busy            = r_busy;
    assign bus.frame_count     = r_frame_count;
    assign bus.timeout_err     = r_err;

endmodule

// File: tb/tb_render_scheduler.sv
// tb/tb_render_scheduler.sv - directed bench for render_scheduler (W=4, H=2, timeout 32)
module tb_render_scheduler;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

`ifdef RENDER_SCHED_DOUBLE_BUFFER_EN
    localparam logic DB = 1'b1;
`else
    localparam logic DB = 1'b0;
`endif

    render_scheduler_if #(.ADDR_BITS(3), .ZBUFFER_DATA_BITS(20)) bus ();

    render_scheduler #(
        .DISPLAY_WIDTH     (4),
        .DISPLAY_HEIGHT    (2),
        .ZBUFFER_DATA_BITS (20),
        .Z_CLEAR           (20'hFFFFF),
        .TIMEOUT_CYCLES    (32),
        .ADDR_BITS         (3)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_front(input int swaps);
        return DB & swaps[0];
    endfunction

    function automatic logic exp_back(input int swaps);
        return DB & ~swaps[0];
    endfunction

    initial begin
        rst                = 1'b1;
        bus.enable         = 1'b0;
        bus.vsync          = 1'b0;
        bus.gen_frame_done = 1'b0;
        bus.clear_color    = 16'h0000;

        // reset state
        tick(2);
        check("rst_busy", bus.busy, 0);
        check("rst_front", bus.front_sel, 0);
        check("rst_back", bus.back_sel, exp_back(0));
        check("rst_fcount", bus.frame_count, 0);
        check("rst_err", bus.timeout_err, 0);
        check("rst_start", bus.gen_frame_start, 0);
        check("rst_wr_en", bus.clr_wr_en, 0);
        check("rst_addr", bus.clr_wr_addr, 0);
        check("rst_z", bus.clr_z_data, 32'hFFFFF);
        check("rst_lock", bus.vram_lock, 0);
        rst = 1'b0;
        tick(1);
        check("idle_busy", bus.busy, 0);

        // frame 1: clear with F800, done after start, vsync later
        bus.enable      = 1'b1;
        bus.clear_color = 16'hF800;
        tick(1);
        for (int i = 0; i < 8; i++) begin
            check("f1_wr_en", bus.clr_wr_en, 1);
            check("f1_addr", bus.clr_wr_addr, i);
            check("f1_fb", bus.clr_fb_data, 32'hF800);
            check("f1_z", bus.clr_z_data, 32'hFFFFF);
            check("f1_lock_clear", bus.vram_lock, 0);
            check("f1_busy", bus.busy, 1);
            tick(1);
        end
        check("f1_start", bus.gen_frame_start, 1);
        check("f1_start_wr_en", bus.clr_wr_en, 0);
        check("f1_start_lock", bus.vram_lock, 1);
        tick(1);
        check("f1_start_pulse", bus.gen_frame_start, 0);
        check("f1_render_lock", bus.vram_lock, 1);
        tick(3);
        bus.gen_frame_done = 1'b1;
        tick(1);
        bus.gen_frame_done = 1'b0;
        check("f1_wait_lock", bus.vram_lock, 0);
        check("f1_wait_busy", bus.busy, 1);
        check("f1_err", bus.timeout_err, 0);
        tick(2);
        bus.vsync       = 1'b1;
        bus.clear_color = 16'h07E0;
        tick(1);
        bus.vsync = 1'b0;
        check("f1_swap_fcount_pre", bus.frame_count, 0);
        tick(1);
        check("f1_fcount", bus.frame_count, 1);
        check("f1_front", bus.front_sel, exp_front(1));
        check("f1_back", bus.back_sel, exp_back(1));
        check("f1_reclear_en", bus.clr_wr_en, 1);
        check("f1_reclear_addr", bus.clr_wr_addr, 0);
        check("f1_relatch", bus.clr_fb_data, 32'h07E0);

        // frame 2: generator never finishes
        tick(8);
        check("f2_start", bus.gen_frame_start, 1);
        tick(31);
        check("f2_err_early", bus.timeout_err, 0);
        check("f2_lock_render", bus.vram_lock, 1);
        tick(2);
        check("f2_err", bus.timeout_err, 1);
        check("f2_lock_wait", bus.vram_lock, 0);
        tick(5);
        check("f2_waiting_busy", bus.busy, 1);
        check("f2_waiting_fcount", bus.frame_count, 1);
        check("f2_waiting_wr_en", bus.clr_wr_en, 0);
        bus.vsync = 1'b1;
        tick(1);
        bus.vsync = 1'b0;
        tick(1);
        check("f2_fcount", bus.frame_count, 2);
        check("f2_front", bus.front_sel, exp_front(2));
        check("f2_err_sticky", bus.timeout_err, 1);
        check("f2_reclear_addr", bus.clr_wr_addr, 0);

        // frame 3: early vsync during render is ignored
        tick(8);
        check("f3_start", bus.gen_frame_start, 1);
        tick(1);
        bus.vsync = 1'b1;
        tick(1);
        bus.vsync = 1'b0;
        tick(2);
        check("f3_still_render", bus.vram_lock, 1);
        bus.gen_frame_done = 1'b1;
        tick(1);
        bus.gen_frame_done = 1'b0;
        tick(10);
        check("f3_no_swap", bus.frame_count, 2);
        check("f3_wait_busy", bus.busy, 1);
        check("f3_wait_wr_en", bus.clr_wr_en, 0);
        bus.vsync = 1'b1;
        tick(1);
        bus.vsync = 1'b0;
        tick(1);
        check("f3_fcount", bus.frame_count, 3);
        check("f3_front", bus.front_sel, exp_front(3));
        check("f3_err_sticky", bus.timeout_err, 1);

        // reset on 4th clear cycle
        tick(3);
        check("rc_addr3", bus.clr_wr_addr, 3);
        rst = 1'b1;
        tick(1);
        check("rc_wr_en", bus.clr_wr_en, 0);
        check("rc_addr", bus.clr_wr_addr, 0);
        check("rc_busy", bus.busy, 0);
        check("rc_err", bus.timeout_err, 0);
        check("rc_fcount", bus.frame_count, 0);
        check("rc_front", bus.front_sel, 0);
        check("rc_back", bus.back_sel, exp_back(0));
        rst = 1'b0;
        tick(1);
        check("rc_fresh_en", bus.clr_wr_en, 1);
        check("rc_fresh_addr", bus.clr_wr_addr, 0);

        // done on the timeout cycle: done wins, no error
        tick(8);
        check("f4_start", bus.gen_frame_start, 1);
        tick(32);
        check("f4_lock_last", bus.vram_lock, 1);
        check("f4_err_last", bus.timeout_err, 0);
        bus.gen_frame_done = 1'b1;
        tick(1);
        bus.gen_frame_done = 1'b0;
        bus.enable         = 1'b0;
        check("f4_lock_wait", bus.vram_lock, 0);
        check("f4_no_err", bus.timeout_err, 0);
        tick(1);
        bus.vsync = 1'b1;
        tick(1);
        bus.vsync = 1'b0;
        tick(1);
        check("f4_idle_busy", bus.busy, 0);
        check("f4_fcount", bus.frame_count, 1);
        check("f4_front", bus.front_sel, exp_front(1));
        check("f4_idle_wr_en", bus.clr_wr_en, 0);
        tick(3);
        check("f4_stay_idle", bus.busy, 0);
        check("f4_stay_wr_en", bus.clr_wr_en, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/render_scheduler.md
# render_scheduler

Per-frame sequencer for the rendering datapath. Each frame it clears the framebuffer and z-buffer to known values, starts the video generator, waits for it to finish, then swaps display buffers on vertical sync. It sits between the host/display timing logic and the `video_generator` + `dpram` instances in the logic clock domain. It also gates host VRAM writes while a frame is being rendered.

## Interface
Parameters:
- `DISPLAY_WIDTH`, 320: pixels per line.
- `DISPLAY_HEIGHT`, 240: lines per frame.
- `ZBUFFER_DATA_BITS`, 20: z-buffer word width.
- `Z_CLEAR`, 20'hFFFFF: z value written during clear (farthest).
- `TIMEOUT_CYCLES`, 1048576: maximum cycles to wait for the generator before aborting the frame.
- `ADDR_BITS`, $clog2(W*H): derived clear-address width (17 at default).

Ports:
- `clk`  in  1  logic clock. Single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  run frames continuously while high.
- `vsync`  in  1  one-cycle vertical-sync pulse, already synchronized to `clk`.
- `clear_color`  in  16  RGB565 background color.
- `gen_frame_start`  out  1  one-cycle start pulse to `video_generator`.
- `gen_frame_done`  in  1  generator completion pulse.
- `clr_wr_en`  out  1  write enable for the framebuffer and z-buffer clear.
- `clr_wr_addr`  out  ADDR_BITS  clear write address.
- `clr_fb_data`  out  16  framebuffer clear data.
- `clr_z_data`  out  ZBUFFER_DATA_BITS  z-buffer clear data, constant `Z_CLEAR`.
- `front_sel`  out  1  buffer being displayed.
- `back_sel`  out  1  buffer being cleared/rendered.
- `vram_lock`  out  1  host must not write VRAM while high.
- `busy`  out  1  high in every state except IDLE.
- `frame_count`  out  16  completed swaps, wraps modulo 2^16.
- `timeout_err`  out  1  sticky; set on generator timeout.

## Operation
States: IDLE, CLEAR, START, RENDER, WAIT_VSYNC, SWAP.
- **IDLE**: if `enable` is high, latch `clear_color`, set address to 0, go to CLEAR.
- **CLEAR**
  - Assert `clr_wr_en` with `clr_wr_addr` = counter, `clr_fb_data` = latched color, `clr_z_data` = `Z_CLEAR`.
  - Counter increments by 1 per cycle.
  - On the cycle with address W*H-1, go to START.
- **START**: assert `gen_frame_start` for exactly one cycle; clear the watchdog; go to RENDER.
- **RENDER**
  - Watchdog increments each cycle.
  - If `gen_frame_done`, go to WAIT_VSYNC.
  - Else if watchdog == TIMEOUT_CYCLES-1, set `timeout_err` and go to WAIT_VSYNC.
  - If `gen_frame_done` arrives on the timeout cycle, done wins and no error is set.
- **WAIT_VSYNC**: on `vsync`, go to SWAP. A `vsync` arriving in any other state is ignored, and the frame waits for the next one.
- **SWAP**
  - Toggle the buffer selects and increment `frame_count`.
  - Go to CLEAR (re-latching `clear_color`) if `enable` is high, else go to IDLE.
- Dropping `enable` mid-frame does not abort: the current frame completes through SWAP, then the block goes to IDLE.
- `vram_lock` is high in START and RENDER only.
- `back_sel` is always the complement of `front_sel` when double buffering is enabled.
- `timeout_err` clears only on `rst`.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Reset values:
  - State is IDLE.
  - `front_sel` = 0, `back_sel` = 1 (0 when double buffering is disabled).
  - All other outputs are 0, except `clr_z_data` = `Z_CLEAR`.
- Latencies:
  - `enable` sampled high in IDLE, cycle t: first `clr_wr_en` at t+1.
  - The clear lasts exactly W*H consecutive cycles.
  - `gen_frame_start` is high in the cycle after the last clear write.
  - `gen_frame_done` at cycle t: state is WAIT_VSYNC at t+1.
  - `vsync` at t: SWAP at t+1, and the new `front_sel` and `frame_count` are visible at t+2.
- Synchronous `rst` in any state: IDLE and reset values on the next edge. A clear in progress is abandoned.

## Configuration
- Macro: `RENDER_SCHED_DOUBLE_BUFFER_EN`.
- Defined:
  - Two framebuffer halves; `front_sel`/`back_sel` toggle in SWAP.
  - SWAP waits for `vsync` as described above.
- Undefined:
  - Single buffer; `front_sel` and `back_sel` are tied to 0.
  - SWAP only increments `frame_count`.
  - WAIT_VSYNC is still honored, so the clear never overlaps active display of the same frame.

## Test plan
Use W=4, H=2, TIMEOUT_CYCLES=32.
- Hold `rst` 2 cycles, then release → state IDLE, `busy`=0, `front_sel`=0, `back_sel`=1, `frame_count`=0, `timeout_err`=0, `gen_frame_start`=0.
- `enable`=1, `clear_color`=16'hF800 → `clr_wr_en` high for 8 cycles with addresses 0..7, data F800/FFFFF; then one-cycle `gen_frame_start`; `vram_lock`=1 from START onward.
- `gen_frame_done` 5 cycles after start, `vsync` 3 cycles later → `vram_lock` drops, `front_sel`=1, `back_sel`=0, `frame_count`=1, clear restarts at address 0.
- Never assert `gen_frame_done` → `timeout_err`=1 exactly 32 cycles after START; the block waits for `vsync`; error stays set through later good frames until `rst`.
- Pulse `vsync` during RENDER, then `gen_frame_done`, then `vsync` 10 cycles later → no swap on the first `vsync`; the swap occurs after the second.
- Assert `rst` on the 4th clear cycle → IDLE next cycle, `clr_wr_en`=0, address 0; with `enable` held, a fresh clear starts from address 0.
